// File: rtl/dff_share_arbiter.sv
// Four-requester round-robin arbiter that owns one shared DW-bit register.
// The registered grantee writes its lane each cycle, and is handed off after HOLD_MAX writes when contended.
module dff_share_arbiter #(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      grant,
  output logic [DW-1:0]   q,
  output logic [1:0]      owner,
  output logic            busy
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [3:0] CNT_TOP = 4'(HOLD_MAX - 1);

  state_t        state, state_n;
  logic [3:0]    grant_n;
  logic [DW-1:0] q_n;
  logic [1:0]    owner_n;
  logic [1:0]    ptr, ptr_n;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    others;

  // First set bit of r when scanning base, base+1, ... (mod 4); callers guarantee r != 0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign others = req & ~grant;
  assign busy   = |grant;

  always_comb begin
    state_n = state;
    grant_n = grant;
    q_n     = q;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_n = pick(req, ptr);
          grant_n = 4'b0001 << owner_n;
          cnt_n   = '0;
          state_n = OWN;
        end
      end
      OWN: begin
        if (req[owner]) begin
          q_n = wdata[owner*DW +: DW];
          // Handoff happens on the same edge as the final write of the tenure.
          if (cnt == CNT_TOP && |others) begin
            owner_n = pick(others, owner + 2'd1);
            grant_n = 4'b0001 << owner_n;
            cnt_n   = '0;
            ptr_n   = owner_n;
          end else if (cnt != CNT_TOP) begin
            cnt_n = cnt + 4'd1;
          end
        end else begin
          grant_n = '0;
          ptr_n   = owner + 2'd1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      q     <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      q     <= q_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Scoreboard bench for dff_share_arbiter: stimulus queues expected outputs,
// a monitor pops one entry after every clock edge or reset assertion.
module tb_dff_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  grant;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [7:0] q;
    logic [1:0] o;
    logic       b;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  dff_share_arbiter #(.DW(8), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .grant (grant),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (grant !== e.g || q !== e.q || owner !== e.o || busy !== e.b) begin
          failures++;
          $display("FAIL %s: got grant=%b q=%h owner=%0d busy=%b, want grant=%b q=%h owner=%0d busy=%b",
                   e.name, grant, q, owner, busy, e.g, e.q, e.o, e.b);
        end
      end
    end
  end

  task automatic push(input string n, input logic [3:0] g, input logic [7:0] qq, input logic [1:0] o);
    exp_t x;
    x.name = n;
    x.g    = g;
    x.q    = qq;
    x.o    = o;
    x.b    = |g;
    expq.push_back(x);
  endtask

  // Called in the low phase: drive inputs, queue the state expected after the next rising edge.
  task automatic cyc(input logic [3:0] r, input logic [31:0] w, input string n,
                     input logic [3:0] g, input logic [7:0] qq, input logic [1:0] o);
    push(n, g, qq, o);
    req   = r;
    wdata = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_rst(input string n);
    push(n, 4'b0000, 8'h00, 2'd0);
    rst = 1'b1;
    #2;
  endtask

  initial begin
    #1;
    async_rst("rst_async_initial");
    @(negedge clk);
    // Reset held with every requester active
    for (int i = 0; i < 3; i++)
      cyc(4'b1111, 32'hFFFF_FFFF, $sformatf("rst_held_%0d", i), 4'b0000, 8'h00, 2'd0);
    rst = 1'b0;
    cyc(4'b0000, 32'h0, "idle_hold", 4'b0000, 8'h00, 2'd0);

    // Single requester on lane 2
    cyc(4'b0100, 32'h44A5_2211, "single_grant", 4'b0100, 8'h00, 2'd2);
    for (int i = 0; i < 3; i++)
      cyc(4'b0100, 32'h44A5_2211, $sformatf("single_write_%0d", i), 4'b0100, 8'hA5, 2'd2);
    cyc(4'b0000, 32'h44A5_2211, "single_release", 4'b0000, 8'hA5, 2'd2);
    cyc(4'b1111, 32'h44A5_2211, "rr_ptr3_first", 4'b1000, 8'hA5, 2'd3);
    cyc(4'b0000, 32'h44A5_2211, "rr_release", 4'b0000, 8'hA5, 2'd3);

    // Contention limit between requesters 0 and 1
    cyc(4'b0011, 32'h0000_2211, "cont_grant0", 4'b0001, 8'hA5, 2'd0);
    for (int i = 0; i < 3; i++)
      cyc(4'b0011, 32'h0000_2211, $sformatf("cont_w0_%0d", i), 4'b0001, 8'h11, 2'd0);
    cyc(4'b0011, 32'h0000_2211, "cont_handoff_to1", 4'b0010, 8'h11, 2'd1);
    for (int i = 0; i < 3; i++)
      cyc(4'b0011, 32'h0000_2211, $sformatf("cont_w1_%0d", i), 4'b0010, 8'h22, 2'd1);
    cyc(4'b0011, 32'h0000_2211, "cont_handoff_to0", 4'b0001, 8'h22, 2'd0);
    cyc(4'b0011, 32'h0000_2211, "cont_w0_again", 4'b0001, 8'h11, 2'd0);
    cyc(4'b0000, 32'h0000_2211, "cont_release", 4'b0000, 8'h11, 2'd0);

    // Uncontended hold on lane 3, then late contention after saturation
    cyc(4'b1000, 32'h2F00_0000, "hold_grant3", 4'b1000, 8'h11, 2'd3);
    for (int i = 0; i < 10; i++)
      cyc(4'b1000, {8'h30 + 8'(i), 24'h0}, $sformatf("hold_write_%0d", i),
          4'b1000, 8'h30 + 8'(i), 2'd3);
    cyc(4'b1010, 32'h3A00_5500, "late_contention_handoff", 4'b0010, 8'h3A, 2'd1);
    cyc(4'b0000, 32'h3A00_5500, "late_release", 4'b0000, 8'h3A, 2'd1);

    // Owner 1 releases on the same edge requester 2 arrives
    cyc(4'b0010, 32'h0000_5A00, "sr_grant1", 4'b0010, 8'h3A, 2'd1);
    cyc(4'b0010, 32'h0000_5A00, "sr_write1", 4'b0010, 8'h5A, 2'd1);
    cyc(4'b0100, 32'h006B_5A00, "sr_gap", 4'b0000, 8'h5A, 2'd1);
    cyc(4'b0100, 32'h006B_5A00, "sr_grant2", 4'b0100, 8'h5A, 2'd2);
    cyc(4'b0100, 32'h006B_5A00, "sr_write2", 4'b0100, 8'h6B, 2'd2);

    // Reset during owner 3's burst
    cyc(4'b0000, 32'h006B_5A00, "mr_release2", 4'b0000, 8'h6B, 2'd2);
    cyc(4'b1000, 32'hC300_0000, "mr_grant3", 4'b1000, 8'h6B, 2'd3);
    cyc(4'b1000, 32'hC300_0000, "mr_write_c3", 4'b1000, 8'hC3, 2'd3);
    cyc(4'b1000, 32'hC400_0000, "mr_write_c4", 4'b1000, 8'hC4, 2'd3);
    async_rst("mr_async_clear");
    cyc(4'b1000, 32'hC500_0000, "mr_rst_held", 4'b0000, 8'h00, 2'd0);
    rst = 1'b0;
    cyc(4'b1001, 32'hC500_00D0, "post_rst_grant0", 4'b0001, 8'h00, 2'd0);
    cyc(4'b1001, 32'hC500_00D0, "post_rst_write0", 4'b0001, 8'hD0, 2'd0);
    cyc(4'b0000, 32'hC500_00D0, "post_rst_release", 4'b0000, 8'hD0, 2'd0);

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dff_share_arbiter.md
DFF_SHARE_ARBITER -- requirements
Module: dff_share_arbiter

Interface
REQ-001 Parameter DW, default 8, width of the shared D-flip-flop register and of each write-data lane.
REQ-002 Parameter HOLD_MAX, default 4, maximum consecutive writes per tenure while another requester waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  request bits; req[i] is held high by requester i while it wants to write.
REQ-006 wdata  input  4*DW  write data; requester i data at bits [i*DW +: DW].
REQ-007 grant  output  4  registered one-hot grant, or all zero.
REQ-008 q  output  DW  shared register contents.
REQ-009 owner  output  2  index of current or last grantee.
REQ-010 busy  output  1  high while a grant is held.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (grant==0, busy==0) and OWN (grant one-hot, busy==1).
REQ-012 A 2-bit round-robin pointer ptr SHALL define priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 In IDLE with req!=0, the next edge SHALL do the following: grant the first requesting index in ptr order; set owner to it; clear the hold counter cnt; enter OWN. q SHALL be unchanged.
REQ-014 In IDLE with req==0, all state SHALL hold.
REQ-015 In OWN with req[owner]==1, each edge SHALL load q <= wdata lane owner.
REQ-016 In OWN with req[owner]==1, cnt==HOLD_MAX-1 and at least one other req bit high, the same edge SHALL do the following: hand off the grant directly to the first other requester in order owner+1, owner+2, owner+3; update owner; clear cnt; set ptr <= new owner; stay in OWN.
REQ-017 In OWN with req[owner]==1 and no handoff, cnt SHALL increment, saturating at HOLD_MAX-1; an uncontended owner keeps the grant indefinitely.
REQ-018 Contention arising after cnt has saturated SHALL trigger a handoff on the first edge at which it is seen.
REQ-019 In OWN with req[owner]==0, the next edge SHALL do the following: clear grant; set ptr <= owner+1 (mod 4); enter IDLE. q and owner SHALL be unchanged.
REQ-020 Re-arbitration after a release SHALL take one IDLE cycle, giving a one-cycle grant gap.
REQ-021 The grant SHALL lead the first write by one cycle: at most one write per cycle.
REQ-022 Writes SHALL come only from the lane of the registered grantee; wdata of non-granted requesters SHALL be ignored.
REQ-023 Request bits of non-owners that toggle during OWN SHALL have no effect except through REQ-016/REQ-018.
REQ-024 grant SHALL never have more than one bit set. busy SHALL equal |grant.

Reset
REQ-025 rst high SHALL immediately, without waiting for clk, force: q=0, grant=0, owner=0, busy=0, ptr=0, cnt=0, state IDLE.
REQ-026 Reset asserted mid-tenure SHALL abort the tenure with no further write.
REQ-027 After rst falls, the first edge with req!=0 SHALL behave per REQ-013, with requester 0 highest priority.

Verification
REQ-028 The bench SHALL cover these directed scenarios (DW=8, HOLD_MAX=4):
- Reset: rst=1 with req=4'b1111 and clk running -> grant=0, q=8'h00, busy=0 throughout; async clear checked with rst asserted between edges.
- Single requester: req=4'b0100, lane2=8'hA5 for 3 cycles, then drop. Expected sequence:
  - edge1: grant=4'b0100, owner=2.
  - edges 2-4: q=8'hA5.
  - edge after drop: grant=0.
  - re-request: requester 3 ranks first (ptr=3).
- Contention limit: req=4'b0011 held, lane0=8'h11, lane1=8'h22. Expected sequence:
  - requester 0 granted; q=8'h11 after exactly 4 write edges.
  - grant becomes 4'b0010 on that 4th write edge.
  - q=8'h22 next edge.
  - after 4 more writes, grant returns to 4'b0001.
- Uncontended hold: req=4'b1000 for 10 cycles -> grant stays 4'b1000; q follows lane3 every cycle; no gap.
- Simultaneous release/request: owner 1 drops req on the same edge req[2] rises -> one cycle grant=0, then grant=4'b0100.
- Reset mid-tenure: rst pulses during owner 3's write burst -> grant=0 and q=0 at once; afterwards req=4'b1001 grants requester 0.
